// File: rtl/hex_display_pkg.sv
// rtl/hex_display_pkg.sv - shared types and glyph constants for the hex digit scanner
package hex_display_pkg;

   typedef enum logic {
      BLANK = 1'b0,
      SHOW  = 1'b1
   } state_t;

   localparam logic [6:0] SEG_OFF = 7'b111_1111;

   // Active-low segments, bit 6 = middle, bit 0 = top
   localparam logic [6:0] GLYPH_TABLE [16] = '{
      7'b100_0000, 7'b111_1001, 7'b010_0100, 7'b011_0000,
      7'b001_1001, 7'b001_0010, 7'b000_0010, 7'b111_1000,
      7'b000_0000, 7'b001_0000, 7'b000_1000, 7'b000_0011,
      7'b100_0110, 7'b010_0001, 7'b000_0110, 7'b000_1110
   };

endpackage

// File: rtl/hex_glyph_rom.sv
// rtl/hex_glyph_rom.sv - combinational nibble to active-low 7-segment glyph lookup
module hex_glyph_rom
   import hex_display_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [0:6] seg
);

   logic [6:0] glyph;

   assign glyph = GLYPH_TABLE[nibble];

   // The bus is declared [0:6]; map by bit number so seg[k] is segment k
   assign seg = {glyph[0], glyph[1], glyph[2], glyph[3], glyph[4], glyph[5], glyph[6]};

endmodule

// File: rtl/hex_display_scanner.sv
// rtl/hex_display_scanner.sv - time-multiplexed scan of a shared-bus 7-segment bank
module hex_display_scanner
   import hex_display_pkg::*;
#(
   parameter int NUM_DIGITS      = 4,
   parameter int TICKS_PER_DIGIT = 50000,
   parameter int BLANK_TICKS     = 16
) (
   input  logic                    Clock,
   input  logic                    Resetn,
   input  logic                    load_valid,
   input  logic [4*NUM_DIGITS-1:0] load_data,
   output logic                    load_ready,
   input  logic                    blank_zeros,
   output logic [0:6]              Display,
   output logic [NUM_DIGITS-1:0]   DigitEn,
   output logic                    frame_done
);

   localparam int MAX_TICKS = (TICKS_PER_DIGIT > BLANK_TICKS) ? TICKS_PER_DIGIT : BLANK_TICKS;
   localparam int CNT_W     = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;
   localparam int IDX_W     = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int DW        = 4 * NUM_DIGITS;

   localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(TICKS_PER_DIGIT - 1);
   localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_TICKS > 0) ? BLANK_TICKS - 1 : 0);
   localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
   // With no dead time the scanner lives entirely in SHOW
   localparam state_t GAP_STATE = (BLANK_TICKS > 0) ? BLANK : SHOW;

   state_t                  state, state_nxt;
   logic [CNT_W-1:0]        cnt, cnt_nxt;
   logic [IDX_W-1:0]        idx, idx_nxt;
   logic [DW-1:0]           shadow, shadow_nxt;
   logic [DW-1:0]           pend_data, pend_data_nxt;
   logic                    pending, pending_nxt;
   logic                    wrap;
   logic [NUM_DIGITS-1:0]   lead_zero;
   logic [3:0]              rom_nibble;
   logic [0:6]              rom_seg;
   logic                    lit_nxt;
   logic [0:6]              display_nxt;
   logic [NUM_DIGITS-1:0]   digit_en_nxt;

   assign load_ready = ~pending;

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt + 1'b1;
      idx_nxt   = idx;
      wrap      = 1'b0;
      case (state)
         BLANK: begin
            if (cnt == BLANK_LAST) begin
               state_nxt = SHOW;
               cnt_nxt   = '0;
            end
         end
         SHOW: begin
            if (cnt == SHOW_LAST) begin
               state_nxt = GAP_STATE;
               cnt_nxt   = '0;
               wrap      = (idx == IDX_LAST);
               idx_nxt   = (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end
         end
         default: ;
      endcase
   end

   // A held value only reaches the shadow at a frame wrap, so frames never mix
   always_comb begin
      shadow_nxt    = shadow;
      pending_nxt   = pending;
      pend_data_nxt = pend_data;
      if (wrap && pending) begin
         shadow_nxt  = pend_data;
         pending_nxt = 1'b0;
      end
      if (load_valid && !pending) begin
         pending_nxt   = 1'b1;
         pend_data_nxt = load_data;
      end
   end

   always_comb begin
      lead_zero = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         lead_zero[i] = 1'b1;
         for (int j = i; j < NUM_DIGITS; j++) begin
            if (shadow_nxt[4*j +: 4] != 4'h0) lead_zero[i] = 1'b0;
         end
      end
   end

   // Outputs are registered from next-state values so they move with the state edge
   assign rom_nibble = shadow_nxt[4*idx_nxt +: 4];

   hex_glyph_rom u_glyph (
      .nibble (rom_nibble),
      .seg    (rom_seg)
   );

   always_comb begin
      lit_nxt      = (state_nxt == SHOW) &&
                     !(blank_zeros && (idx_nxt != '0) && lead_zero[idx_nxt]);
      display_nxt  = SEG_OFF;
      digit_en_nxt = '1;
      if (lit_nxt) begin
         display_nxt           = rom_seg;
         digit_en_nxt[idx_nxt] = 1'b0;
      end
   end

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         state      <= GAP_STATE;
         cnt        <= '0;
         idx        <= '0;
         shadow     <= '0;
         pend_data  <= '0;
         pending    <= 1'b0;
         Display    <= SEG_OFF;
         DigitEn    <= '1;
         frame_done <= 1'b0;
      end else begin
         state      <= state_nxt;
         cnt        <= cnt_nxt;
         idx        <= idx_nxt;
         shadow     <= shadow_nxt;
         pend_data  <= pend_data_nxt;
         pending    <= pending_nxt;
         Display    <= display_nxt;
         DigitEn    <= digit_en_nxt;
         frame_done <= wrap;
      end
   end

endmodule

// File: tb/tb_hex_display_scanner.sv
// tb/tb_hex_display_scanner.sv - directed self-checking bench for hex_display_scanner
module tb_hex_display_scanner;

   logic        Clock = 1'b0;
   logic        Resetn = 1'b0;
   logic        load_valid = 1'b0;
   logic [15:0] load_data = 16'h0;
   logic        blank_zeros = 1'b0;
   logic        load_ready;
   logic [0:6]  Display;
   logic [3:0]  DigitEn;
   logic        frame_done;

   logic [6:0]  seg;
   int          compared = 0;
   int          mismatched = 0;
   int          s = 0;
   int          commit_at = -1;
   logic [15:0] shown = 16'h0;
   logic [15:0] commit_val = 16'h0;
   logic [3:0]  exp_en;
   logic [6:0]  exp_seg;
   logic        exp_fd;

   hex_display_scanner #(
      .NUM_DIGITS      (4),
      .TICKS_PER_DIGIT (4),
      .BLANK_TICKS     (2)
   ) dut (
      .Clock       (Clock),
      .Resetn      (Resetn),
      .load_valid  (load_valid),
      .load_data   (load_data),
      .load_ready  (load_ready),
      .blank_zeros (blank_zeros),
      .Display     (Display),
      .DigitEn     (DigitEn),
      .frame_done  (frame_done)
   );

   always #5 Clock = ~Clock;

   assign seg = {Display[6], Display[5], Display[4], Display[3], Display[2], Display[1], Display[0]};

   function automatic logic [6:0] glyph(input logic [3:0] n);
      case (n)
         4'h0: glyph = 7'b100_0000;  4'h1: glyph = 7'b111_1001;
         4'h2: glyph = 7'b010_0100;  4'h3: glyph = 7'b011_0000;
         4'h4: glyph = 7'b001_1001;  4'h5: glyph = 7'b001_0010;
         4'h6: glyph = 7'b000_0010;  4'h7: glyph = 7'b111_1000;
         4'h8: glyph = 7'b000_0000;  4'h9: glyph = 7'b001_0000;
         4'hA: glyph = 7'b000_1000;  4'hB: glyph = 7'b000_0011;
         4'hC: glyph = 7'b100_0110;  4'hD: glyph = 7'b010_0001;
         4'hE: glyph = 7'b000_0110;  default: glyph = 7'b000_1110;
      endcase
   endfunction

   // Frame = 4 slots of 6 cycles: 2 dark, then 4 lit; s counts edges since reset release
   function automatic void compute_exp();
      int p, slot, w;
      p       = s % 24;
      slot    = p / 6;
      w       = p % 6;
      exp_en  = 4'hF;
      exp_seg = 7'h7F;
      exp_fd  = (s > 0) && (p == 0);
      if (w >= 2 && !(blank_zeros && slot > 0 && (shown >> (4 * slot)) == 16'h0)) begin
         exp_en[slot] = 1'b0;
         exp_seg      = glyph(shown[4*slot +: 4]);
      end
   endfunction

   task automatic advance();
      @(negedge Clock);
      s++;
      if (s == commit_at) shown = commit_val;
      compute_exp();
   endtask

   task automatic test_reset();
      Resetn = 1'b0;
      repeat (3) @(negedge Clock);
      #1;
      compared++;
      if (seg !== 7'h7F || DigitEn !== 4'hF) begin
         mismatched++;
         $display("FAIL reset_outputs: got seg=%b en=%b, want 1111111 1111", seg, DigitEn);
      end
      compared++;
      if (load_ready !== 1'b1 || frame_done !== 1'b0) begin
         mismatched++;
         $display("FAIL reset_flags: got ready=%b fd=%b, want 1 0", load_ready, frame_done);
      end
      Resetn = 1'b1;
      s = 0;
      shown = 16'h0;
      commit_at = -1;
      compute_exp();
      while (s < 49) begin
         compared++;
         if (DigitEn !== exp_en || seg !== exp_seg || frame_done !== exp_fd) begin
            mismatched++;
            $display("FAIL reset_scan s=%0d: got en=%b seg=%b fd=%b, want en=%b seg=%b fd=%b", s, DigitEn, seg, frame_done, exp_en, exp_seg, exp_fd);
         end
         if (s == 1 || s == 2 || s == 24) begin
            compared++;
            if ((s == 1 && DigitEn !== 4'b1111) || (s == 2 && (DigitEn !== 4'b1110 || seg !== 7'b100_0000)) || (s == 24 && frame_done !== 1'b1)) begin
               mismatched++;
               $display("FAIL reset_literal s=%0d: got en=%b seg=%b fd=%b", s, DigitEn, seg, frame_done);
            end
         end
         advance();
      end
   endtask

   task automatic test_load_midframe();
      load_valid = 1'b1;
      load_data  = 16'h12AF;
      advance();
      load_valid = 1'b0;
      commit_val = 16'h12AF;
      commit_at  = 72;
      compared++;
      if (load_ready !== 1'b0) begin
         mismatched++;
         $display("FAIL load_ready_drop: got %b, want 0", load_ready);
      end
      while (s < 95) begin
         compared++;
         if (DigitEn !== exp_en || seg !== exp_seg || frame_done !== exp_fd) begin
            mismatched++;
            $display("FAIL load_scan s=%0d: got en=%b seg=%b fd=%b, want en=%b seg=%b fd=%b", s, DigitEn, seg, frame_done, exp_en, exp_seg, exp_fd);
         end
         if (s == 74 || s == 80 || s == 86 || s == 92) begin
            compared++;
            if ((s == 74 && (DigitEn !== 4'b1110 || seg !== 7'b000_1110)) ||
                (s == 80 && (DigitEn !== 4'b1101 || seg !== 7'b000_1000)) ||
                (s == 86 && (DigitEn !== 4'b1011 || seg !== 7'b010_0100)) ||
                (s == 92 && (DigitEn !== 4'b0111 || seg !== 7'b111_1001))) begin
               mismatched++;
               $display("FAIL load_glyph s=%0d: got en=%b seg=%b", s, DigitEn, seg);
            end
         end
         if (s == 71 || s == 72) begin
            compared++;
            if (load_ready !== (s == 72)) begin
               mismatched++;
               $display("FAIL load_ready_wrap s=%0d: got %b", s, load_ready);
            end
         end
         advance();
      end
   endtask

   task automatic test_back_to_back();
      while (s < 100) advance();
      load_valid = 1'b1;
      load_data  = 16'h3456;
      advance();
      commit_val = 16'h3456;
      commit_at  = 120;
      load_data  = 16'h789C;
      while (s < 146) begin
         compared++;
         if (DigitEn !== exp_en || seg !== exp_seg || frame_done !== exp_fd) begin
            mismatched++;
            $display("FAIL b2b_scan s=%0d: got en=%b seg=%b fd=%b, want en=%b seg=%b fd=%b", s, DigitEn, seg, frame_done, exp_en, exp_seg, exp_fd);
         end
         if (s <= 121) begin
            compared++;
            if (load_ready !== (s == 120)) begin
               mismatched++;
               $display("FAIL b2b_ready s=%0d: got %b, want %b", s, load_ready, (s == 120));
            end
         end
         if (s == 121) begin
            load_valid = 1'b0;
            commit_val = 16'h789C;
            commit_at  = 144;
         end
         if (s == 122) begin
            compared++;
            if (DigitEn !== 4'b1110 || seg !== 7'b000_0010) begin
               mismatched++;
               $display("FAIL b2b_first s=%0d: got en=%b seg=%b, want 1110 0000010", s, DigitEn, seg);
            end
         end
         advance();
      end
      compared++;
      if (DigitEn !== 4'b1110 || seg !== 7'b100_0110) begin
         mismatched++;
         $display("FAIL b2b_second s=%0d: got en=%b seg=%b, want 1110 1000110", s, DigitEn, seg);
      end
   endtask

   task automatic test_blank_zeros();
      logic [15:0] vals [3];
      logic [3:0]  lit_en [3][4];
      logic [6:0]  lit_seg [3][4];
      vals    = '{16'h0005, 16'h0000, 16'h0400};
      lit_en  = '{'{4'b1110, 4'b1111, 4'b1111, 4'b1111},
                  '{4'b1110, 4'b1111, 4'b1111, 4'b1111},
                  '{4'b1110, 4'b1101, 4'b1011, 4'b1111}};
      lit_seg = '{'{7'b001_0010, 7'h7F, 7'h7F, 7'h7F},
                  '{7'b100_0000, 7'h7F, 7'h7F, 7'h7F},
                  '{7'b100_0000, 7'b100_0000, 7'b001_1001, 7'h7F}};
      blank_zeros = 1'b1;
      for (int v = 0; v < 3; v++) begin
         load_valid = 1'b1;
         load_data  = vals[v];
         advance();
         load_valid = 1'b0;
         commit_val = vals[v];
         commit_at  = (s / 24 + 1) * 24;
         while (s < commit_at + 21) begin
            compared++;
            if (DigitEn !== exp_en || seg !== exp_seg || frame_done !== exp_fd) begin
               mismatched++;
               $display("FAIL bz_scan s=%0d: got en=%b seg=%b fd=%b, want en=%b seg=%b fd=%b", s, DigitEn, seg, frame_done, exp_en, exp_seg, exp_fd);
            end
            for (int k = 0; k < 4; k++) begin
               if (s == commit_at + 2 + 6 * k) begin
                  compared++;
                  if (DigitEn !== lit_en[v][k] || seg !== lit_seg[v][k]) begin
                     mismatched++;
                     $display("FAIL bz_digit val=%h slot=%0d: got en=%b seg=%b, want en=%b seg=%b", vals[v], k, DigitEn, seg, lit_en[v][k], lit_seg[v][k]);
                  end
               end
            end
            advance();
         end
      end
   endtask

   task automatic test_wrap_transfer();
      blank_zeros = 1'b0;
      advance();
      while (s < 239) advance();
      load_valid = 1'b1;
      load_data  = 16'hE00B;
      advance();
      load_valid = 1'b0;
      commit_val = 16'hE00B;
      commit_at  = 264;
      compared++;
      if (frame_done !== 1'b1 || load_ready !== 1'b0) begin
         mismatched++;
         $display("FAIL wrap_edge s=%0d: got fd=%b ready=%b, want 1 0", s, frame_done, load_ready);
      end
      while (s < 266) begin
         compared++;
         if (DigitEn !== exp_en || seg !== exp_seg || frame_done !== exp_fd) begin
            mismatched++;
            $display("FAIL wrap_scan s=%0d: got en=%b seg=%b fd=%b, want en=%b seg=%b fd=%b", s, DigitEn, seg, frame_done, exp_en, exp_seg, exp_fd);
         end
         if (s == 242) begin
            compared++;
            if (DigitEn !== 4'b1110 || seg !== 7'b100_0000) begin
               mismatched++;
               $display("FAIL wrap_old s=%0d: got en=%b seg=%b, want 1110 1000000", s, DigitEn, seg);
            end
         end
         if (s == 263 || s == 264) begin
            compared++;
            if (load_ready !== (s == 264)) begin
               mismatched++;
               $display("FAIL wrap_ready s=%0d: got %b", s, load_ready);
            end
         end
         advance();
      end
      compared++;
      if (DigitEn !== 4'b1110 || seg !== 7'b000_0011) begin
         mismatched++;
         $display("FAIL wrap_new s=%0d: got en=%b seg=%b, want 1110 0000011", s, DigitEn, seg);
      end
   endtask

   task automatic test_async_reset();
      load_valid = 1'b1;
      load_data  = 16'hFFFF;
      advance();
      load_valid = 1'b0;
      advance();
      compared++;
      if (DigitEn !== 4'b1110 || seg !== 7'b000_0011 || load_ready !== 1'b0) begin
         mismatched++;
         $display("FAIL pre_reset s=%0d: got en=%b seg=%b ready=%b, want 1110 0000011 0", s, DigitEn, seg, load_ready);
      end
      #2 Resetn = 1'b0;
      #1;
      compared++;
      if (seg !== 7'h7F || DigitEn !== 4'hF || load_ready !== 1'b1 || frame_done !== 1'b0) begin
         mismatched++;
         $display("FAIL async_reset: got seg=%b en=%b ready=%b fd=%b, want 1111111 1111 1 0", seg, DigitEn, load_ready, frame_done);
      end
      repeat (2) @(negedge Clock);
      #1 Resetn = 1'b1;
      s = 0;
      shown = 16'h0;
      commit_at = -1;
      compute_exp();
      while (s < 30) begin
         compared++;
         if (DigitEn !== exp_en || seg !== exp_seg || frame_done !== exp_fd || load_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL post_reset s=%0d: got en=%b seg=%b fd=%b ready=%b, want en=%b seg=%b fd=%b ready=1", s, DigitEn, seg, frame_done, load_ready, exp_en, exp_seg, exp_fd);
         end
         if (s == 2) begin
            compared++;
            if (DigitEn !== 4'b1110 || seg !== 7'b100_0000) begin
               mismatched++;
               $display("FAIL post_reset_digit0: got en=%b seg=%b, want 1110 1000000", DigitEn, seg);
            end
         end
         advance();
      end
   endtask

   initial begin
      test_reset();
      test_load_midframe();
      test_back_to_back();
      test_blank_zeros();
      test_wrap_transfer();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/hex_display_scanner.md
Name: hex_display_scanner

Overview:
Time-multiplexed scan controller for a bank of common-anode 7-segment digits that share one segment bus.
- A single hex glyph decoder is shared across NUM_DIGITS positions; digits are driven one at a time, with a dead-time blank between digits to prevent ghosting.
- New display values arrive over a valid/ready handshake and are committed only at frame boundaries, so a frame never mixes old and new digits.
- The block sits between datapath result registers and the board's HEX segment/anode pins.

Parameters:
NUM_DIGITS, 4, number of digit positions (1..8); digit 0 is least significant.
TICKS_PER_DIGIT, 50000, clock cycles each digit is lit (>=1).
BLANK_TICKS, 16, clock cycles all digits are dark between digits (>=0; 0 removes the BLANK state).

Ports:
Clock  in  1  system clock, all state on rising edge.
Resetn  in  1  asynchronous, active-low reset.
load_valid  in  1  producer offers load_data.
load_data  in  4*NUM_DIGITS  packed nibbles; nibble i = digit i.
load_ready  out  1  block can accept a value.
blank_zeros  in  1  enables leading-zero suppression.
Display  out  7 [0:6]  segment bus, active-low; bit 6 = middle segment, bit 0 = top segment.
DigitEn  out  NUM_DIGITS  anode enables, active-low, at most one low.
frame_done  out  1  one-cycle pulse at each frame wrap.

Behaviour:
- Clocking and reset: one clock domain; reset is asynchronous and active-low.
- Reset values:
  - Display = 7'b111_1111; DigitEn = all 1s; load_ready = 1; frame_done = 0.
  - shadow = 0; pending = 0; idx = 0; tick counter = 0; state = BLANK, or SHOW if BLANK_TICKS = 0.
- FSM states:
  - BLANK: DigitEn all high, Display all high. After BLANK_TICKS cycles, go to SHOW.
  - SHOW: DigitEn[idx] = 0; Display = glyph(shadow nibble idx). After TICKS_PER_DIGIT cycles:
    - idx <= idx + 1, wrapping NUM_DIGITS-1 -> 0.
    - Go to BLANK.
- Outputs are registered and change on the same edge as the state change.
- Tick counter:
  - Width = clog2 of max(TICKS_PER_DIGIT, BLANK_TICKS).
  - Clears on every state change.
  - Never exceeds terminal count minus 1.
- Frame period = NUM_DIGITS*(TICKS_PER_DIGIT+BLANK_TICKS) cycles.
- Frame wrap (SHOW exit with idx = NUM_DIGITS-1):
  - frame_done = 1 for exactly that cycle.
  - If pending = 1: shadow <= pending_data and pending <= 0.
- Handshake:
  - load_ready = ~pending.
  - Transfer occurs when load_valid && load_ready: pending_data <= load_data, pending <= 1.
  - load_data is sampled only on a transfer cycle.
- Simultaneous transfer and wrap: because pending = 0, the wrap commits nothing. The new value commits at the following wrap. load_ready drops the cycle after the transfer.
- Leading-zero suppression (blank_zeros = 1):
  - Digit i > 0 is dark during its SHOW slot (DigitEn stays all high, Display all high) when nibbles NUM_DIGITS-1..i of shadow are all zero.
  - Digit 0 is always shown.
  - Suppression is evaluated on shadow, never on pending data.
- Glyph table (active-low, bits 6..0):
  - 0=100_0000, 1=111_1001, 2=010_0100, 3=011_0000, 4=001_1001, 5=001_0010, 6=000_0010, 7=111_1000.
  - 8=000_0000, 9=001_0000, A=000_1000, b=000_0011, C=100_0110, d=010_0001, E=000_0110, F=000_1110.
- Reset asserted mid-operation: all outputs return to reset values immediately (asynchronously). Pending data is discarded.

Decomposition:
- Package hex_display_pkg holds:
  - state enum {BLANK, SHOW};
  - SEG_OFF = 7'b111_1111;
  - the 16-entry glyph constant table.
- One combinational sub-module, hex_glyph_rom (4-bit in, 7-bit [0:6] out), instantiated once and fed by the idx-selected nibble of shadow.
- FSM, counters and handshake logic live in hex_display_scanner.

Test Plan:
All scenarios use NUM_DIGITS=4, TICKS_PER_DIGIT=4, BLANK_TICKS=2.
1. Reset, then release -> outputs all 1s and load_ready=1 for 2 cycles. Then DigitEn=4'b1110 and Display=100_0000 for 4 cycles. frame_done pulses every 24 cycles.
2. Load 16'h12AF mid-frame -> display unchanged until frame_done. In the next frame: digit0 shows 000_1110, digit1 000_1000, digit2 010_0100, digit3 111_1001.
3. Back-pressure: load A, then hold load_valid with B while pending -> load_ready=0 until the wrap. B is accepted the cycle after the wrap and displayed one frame after A.
4. blank_zeros=1 with 16'h0005 -> digits 3..1 stay dark in their slots; digit0 shows 001_0010. With 16'h0000 -> only digit0 lit, showing 100_0000. With 16'h0400 -> digits 2, 1 and 0 shown.
5. Transfer on the exact wrap cycle -> not committed that frame; committed at the next frame_done.
6. Assert Resetn low mid-SHOW with a value pending -> Display and DigitEn go all 1s without a clock edge. After release, digit0 shows 0 and load_ready=1.
